// File: rtl/icache_fetcher_pkg.sv
// Shared types and constants for the instruction-cache fetcher.
package icache_fetcher_pkg;

   typedef logic [31:0] AddrType;
   typedef logic [31:0] WordType;
   typedef logic [31:0] InstrType;

   localparam logic    True     = 1'b1;
   localparam logic    False    = 1'b0;
   localparam WordType ZeroWord = '0;

   typedef enum logic [1:0] {
      IF_IDLE   = 2'd0,
      IF_REFILL = 2'd1,
      IF_DRAIN  = 2'd2
   } if_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid bits, tags and word data.
// Combinational read port, single-word write, line validate and global invalidate.
module icache_array
   import icache_fetcher_pkg::*;
#(
   parameter int TAG_W          = 22,
   parameter int INDEX_BITS     = 6,
   parameter int LINE_WORDS_LOG = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [INDEX_BITS-1:0]     rd_index,
   input  logic [LINE_WORDS_LOG-1:0] rd_word,
   output logic                      rd_valid,
   output logic [TAG_W-1:0]          rd_tag,
   output WordType                   rd_data,
   input  logic                      wr_en,
   input  logic [INDEX_BITS-1:0]     wr_index,
   input  logic [LINE_WORDS_LOG-1:0] wr_word,
   input  WordType                   wr_data,
   input  logic                      val_en,
   input  logic [INDEX_BITS-1:0]     val_index,
   input  logic [TAG_W-1:0]          val_tag,
   input  logic                      inv_en
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int WORDS = LINES << LINE_WORDS_LOG;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   WordType          data [WORDS];

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = data[{rd_index, rd_word}];

   // Valid bits: invalidate wins over a same-cycle validate so fence.i is never lost.
   always_ff @(posedge clk) begin
      if (rst)         valid <= '0;
      else if (inv_en) valid <= '0;
      else if (val_en) valid[val_index] <= 1'b1;
   end

   // Tag is written when the line is validated.
   always_ff @(posedge clk) begin
      if (val_en) tags[val_index] <= val_tag;
   end

   // Refill word write.
   always_ff @(posedge clk) begin
      if (wr_en) data[{wr_index, wr_word}] <= wr_data;
   end

endmodule

// File: rtl/icache_fetcher.sv
// Instruction fetcher with a direct-mapped I-cache and multi-word line refill.
// Optional: define ICACHE_PERF_CNT_EN to add saturating hit/miss counters.
module icache_fetcher
   import icache_fetcher_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int INSTR_W        = 32,
   parameter int INDEX_BITS     = 6,
   parameter int LINE_WORDS_LOG = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               clear_flag_in,
   input  logic [ADDR_W-1:0]  clear_pc_in,
   input  logic               iq_write_pc_sig_in,
   input  logic [ADDR_W-1:0]  iq_write_pc_val_in,
   input  logic               iq_fetch_enable_in,
   output logic               iq_result_enable_out,
   output logic [INSTR_W-1:0] iq_instr_out,
   output logic [ADDR_W-1:0]  iq_pc_out,
   output logic               mc_fetch_enable_out,
   output logic [ADDR_W-1:0]  mc_addr_out,
   input  logic               mc_result_enable_in,
   input  logic [INSTR_W-1:0] mc_data_in,
   input  logic               icache_invalidate_in
`ifdef ICACHE_PERF_CNT_EN
  ,output logic [31:0]        perf_hit_cnt_out
  ,output logic [31:0]        perf_miss_cnt_out
`endif
);

   localparam int OFF   = LINE_WORDS_LOG + 2;
   localparam int TAG_W = ADDR_W - INDEX_BITS - OFF;

   if_state_t                 state, state_n;
   logic [ADDR_W-1:0]         pc, pc_n;
   logic [LINE_WORDS_LOG-1:0] cnt, cnt_n;
   logic                      poison, poison_n;
   logic                      res_en_n, mc_en_n;
   logic [INSTR_W-1:0]        instr_n;
   logic [ADDR_W-1:0]         ipc_n, mc_addr_n;
   logic                      arr_wr, arr_val, arr_inv, hit_inc, miss_inc;

   logic [LINE_WORDS_LOG-1:0] pc_word;
   logic [INDEX_BITS-1:0]     pc_index;
   logic [TAG_W-1:0]          pc_tag, rd_tag;
   logic                      rd_valid, hit, redirect;
   logic [ADDR_W-1:0]         redirect_pc, line_base;
   WordType                   rd_data;

   assign pc_word     = pc[OFF-1:2];
   assign pc_index    = pc[OFF+INDEX_BITS-1:OFF];
   assign pc_tag      = pc[ADDR_W-1:OFF+INDEX_BITS];
   assign line_base   = {pc[ADDR_W-1:OFF], {OFF{1'b0}}};
   assign hit         = rd_valid && (rd_tag == pc_tag);
   assign redirect    = clear_flag_in | iq_write_pc_sig_in;
   assign redirect_pc = clear_flag_in ? clear_pc_in : iq_write_pc_val_in;

   // Storage writes only land when the pipeline is not frozen.
   icache_array #(
      .TAG_W(TAG_W), .INDEX_BITS(INDEX_BITS), .LINE_WORDS_LOG(LINE_WORDS_LOG)
   ) u_array (
      .clk(clk), .rst(rst),
      .rd_index(pc_index), .rd_word(pc_word),
      .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_data(rd_data),
      .wr_en(arr_wr & rdy & ~rst), .wr_index(pc_index), .wr_word(cnt), .wr_data(mc_data_in),
      .val_en(arr_val & rdy & ~rst), .val_index(pc_index), .val_tag(pc_tag),
      .inv_en(arr_inv & rdy & ~rst)
   );

   // Next-state: redirect > invalidate > fetch/refill activity.
   always_comb begin
      state_n   = state;
      pc_n      = pc;
      cnt_n     = cnt;
      poison_n  = poison;
      res_en_n  = False;
      instr_n   = iq_instr_out;
      ipc_n     = iq_pc_out;
      mc_en_n   = mc_fetch_enable_out;
      mc_addr_n = mc_addr_out;
      arr_wr    = False;
      arr_val   = False;
      arr_inv   = False;
      hit_inc   = False;
      miss_inc  = False;
      if (redirect) begin
         pc_n = redirect_pc;
      end else if (icache_invalidate_in) begin
         arr_inv  = True;
         poison_n = True;  // an in-flight line must stay invalid
      end
      case (state)
         IF_IDLE: begin
            if (!redirect && !icache_invalidate_in && iq_fetch_enable_in) begin
               if (hit) begin
                  res_en_n = True;
                  instr_n  = rd_data;
                  ipc_n    = pc;
                  pc_n     = pc + ADDR_W'(4);
                  hit_inc  = True;
               end else begin
                  state_n   = IF_REFILL;
                  cnt_n     = '0;
                  poison_n  = False;
                  mc_en_n   = True;
                  mc_addr_n = line_base;
                  miss_inc  = True;
               end
            end
         end
         IF_REFILL: begin
            if (redirect) begin
               // A word returning this cycle closes the request; otherwise drain it.
               if (mc_result_enable_in) begin
                  state_n = IF_IDLE;
                  mc_en_n = False;
               end else begin
                  state_n = IF_DRAIN;
               end
            end else if (mc_result_enable_in) begin
               arr_wr = True;
               if (cnt == '1) begin
                  arr_val = !poison_n;
                  mc_en_n = False;
                  state_n = IF_IDLE;
               end else begin
                  cnt_n     = cnt + 1'b1;
                  mc_addr_n = mc_addr_out + ADDR_W'(4);
               end
            end
         end
         IF_DRAIN: begin
            if (mc_result_enable_in) begin
               mc_en_n = False;
               state_n = IF_IDLE;
            end
         end
         default: state_n = IF_IDLE;
      endcase
   end

   // State and output registers; frozen while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IF_IDLE;
         pc                   <= '0;
         cnt                  <= '0;
         poison               <= False;
         iq_result_enable_out <= False;
         iq_instr_out         <= ZeroWord;
         iq_pc_out            <= '0;
         mc_fetch_enable_out  <= False;
         mc_addr_out          <= '0;
      end else if (rdy) begin
         state                <= state_n;
         pc                   <= pc_n;
         cnt                  <= cnt_n;
         poison               <= poison_n;
         iq_result_enable_out <= res_en_n;
         iq_instr_out         <= instr_n;
         iq_pc_out            <= ipc_n;
         mc_fetch_enable_out  <= mc_en_n;
         mc_addr_out          <= mc_addr_n;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   // Saturating hit/miss counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_hit_cnt_out  <= '0;
         perf_miss_cnt_out <= '0;
      end else if (rdy) begin
         if (hit_inc && perf_hit_cnt_out != '1)   perf_hit_cnt_out  <= perf_hit_cnt_out + 1'b1;
         if (miss_inc && perf_miss_cnt_out != '1) perf_miss_cnt_out <= perf_miss_cnt_out + 1'b1;
      end
   end
`endif

endmodule
